// File: rtl/line_buffer_ctrl.sv
// Round-robin write steering and 3x3 window read control for four line buffers.
// Three stored lines feed the window while the fourth buffer keeps filling.
module line_buffer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   inPixel,
    input  logic                    inPixelValid,
    output logic                    inPixelReady,
    output logic [DATA_WIDTH-1:0]   lbPixel,
    output logic [3:0]              lbWrValid,
    output logic [3:0]              lbRdReady,
    input  logic [12*DATA_WIDTH-1:0] lbOut,
    output logic [9*DATA_WIDTH-1:0] outWindow,
    output logic                    windowValid,
    input  logic                    windowReady,
    output logic                    lineDoneIrq,
    output logic                    dbgState
);
    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready on the same interface.

    localparam int FILL_W = $clog2(4*IMG_WIDTH+1);
    localparam int PIX_W  = $clog2(IMG_WIDTH);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(4*IMG_WIDTH);
    localparam logic [FILL_W-1:0] THREE    = FILL_W'(3*IMG_WIDTH);
    localparam logic [FILL_W-1:0] LINE     = FILL_W'(IMG_WIDTH);
    localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(IMG_WIDTH-1);
    localparam int ROW_W = 3*DATA_WIDTH;

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    state_t              state;
    logic [1:0]          wr_buf_sel;
    logic [PIX_W-1:0]    wr_pix_cnt;
    logic [1:0]          rd_buf_sel;
    logic [PIX_W-1:0]    rd_pix_cnt;
    logic [FILL_W-1:0]   fill_cnt;
    logic                line_done;

    logic                wr_fire;
    logic                rd_fire;
    logic                last_rd;
    logic                reading;
    logic [FILL_W-1:0]   fill_next;
    logic [1:0]          rd_sel1;
    logic [1:0]          rd_sel2;

    // Ready is held low during reset so no write can leak into a buffer.
    assign inPixelReady = ~rst & (fill_cnt < FULL);
    assign wr_fire      = inPixelValid & inPixelReady;
    assign reading      = (state == READ);
    assign rd_fire      = reading & windowReady;
    assign last_rd      = rd_fire & (rd_pix_cnt == LAST_PIX);
    assign fill_next    = fill_cnt + {{(FILL_W-1){1'b0}}, wr_fire} - (last_rd ? LINE : '0);
    assign rd_sel1      = rd_buf_sel + 2'd1;
    assign rd_sel2      = rd_buf_sel + 2'd2;

    assign lbPixel     = inPixel;
    assign windowValid = reading;
    assign lineDoneIrq = line_done;
    assign dbgState    = state;

    function automatic logic [ROW_W-1:0] row_of(input logic [12*DATA_WIDTH-1:0] bufs,
                                                input logic [1:0] idx);
        int unsigned base;
        base = 32'(idx) * ROW_W;
        return bufs[base +: ROW_W];
    endfunction

    always_comb begin
        lbWrValid = '0;
        lbRdReady = '0;
        outWindow = '0;
        if (wr_fire)
            lbWrValid[wr_buf_sel] = 1'b1;
        if (rd_fire) begin
            lbRdReady[rd_buf_sel] = 1'b1;
            lbRdReady[rd_sel1]    = 1'b1;
            lbRdReady[rd_sel2]    = 1'b1;
        end
        if (reading)
            outWindow = {row_of(lbOut, rd_buf_sel), row_of(lbOut, rd_sel1), row_of(lbOut, rd_sel2)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_buf_sel <= '0;
            wr_pix_cnt <= '0;
            rd_buf_sel <= '0;
            rd_pix_cnt <= '0;
            fill_cnt   <= '0;
            line_done  <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_pix_cnt == LAST_PIX) begin
                    wr_pix_cnt <= '0;
                    wr_buf_sel <= wr_buf_sel + 2'd1;
                end else begin
                    wr_pix_cnt <= wr_pix_cnt + PIX_W'(1);
                end
            end
            if (rd_fire) begin
                if (last_rd) begin
                    rd_pix_cnt <= '0;
                    rd_buf_sel <= rd_buf_sel + 2'd1;
                end else begin
                    rd_pix_cnt <= rd_pix_cnt + PIX_W'(1);
                end
            end
            line_done <= last_rd;
            fill_cnt  <= fill_next;
            // Staying in READ across a line end keeps back-to-back lines gap-free.
            case (state)
                IDLE: if (fill_cnt >= THREE) state <= READ;
                READ: if (last_rd && (fill_next < THREE)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with IMG_WIDTH = 8 and fixed buffer outputs.
module tb_line_buffer_ctrl;
    localparam int DW = 8;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_pixel = '0;
    logic          in_pixel_valid = 1'b0;
    logic          in_pixel_ready;
    logic [DW-1:0] lb_pixel;
    logic [3:0]    lb_wr_valid;
    logic [3:0]    lb_rd_ready;
    logic [12*DW-1:0] lb_out = 96'hA3B3C3_A2B2C2_A1B1C1_A0B0C0;
    logic [9*DW-1:0]  out_window;
    logic          window_valid;
    logic          window_ready = 1'b0;
    logic          line_done_irq;
    logic          dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [71:0] WIN_SEL0 = 72'hA0B0C0_A1B1C1_A2B2C2;
    localparam logic [71:0] WIN_SEL1 = 72'hA1B1C1_A2B2C2_A3B3C3;
    localparam logic [71:0] WIN_SEL2 = 72'hA2B2C2_A3B3C3_A0B0C0;

    line_buffer_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .inPixel(in_pixel), .inPixelValid(in_pixel_valid), .inPixelReady(in_pixel_ready),
        .lbPixel(lb_pixel), .lbWrValid(lb_wr_valid), .lbRdReady(lb_rd_ready),
        .lbOut(lb_out), .outWindow(out_window), .windowValid(window_valid),
        .windowReady(window_ready), .lineDoneIrq(line_done_irq), .dbgState(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge and settle before sampling.
    task automatic drive(input logic v, input logic [DW-1:0] px, input logic r);
        @(negedge clk);
        in_pixel_valid = v;
        in_pixel       = px;
        window_ready   = r;
        #1;
    endtask

    initial begin
        int sent, pulses, gaps, cyc;
        bit seen_valid;
        int sel_tab[6];
        sel_tab = '{1, 2, 3, 0, 1, 2};

        // Reset state, with a valid pixel presented to prove writes are blocked.
        @(negedge clk);
        in_pixel = 8'h5A;
        in_pixel_valid = 1'b1;
        #1;
        check_eq("rst_ready", in_pixel_ready, 0);
        check_eq("rst_wr", lb_wr_valid, 0);
        check_eq("rst_rd", lb_rd_ready, 0);
        check_eq("rst_wvalid", window_valid, 0);
        check_eq("rst_window", out_window, 0);
        check_eq("rst_irq", line_done_irq, 0);
        check_eq("rst_lbpixel", lb_pixel, 8'h5A);
        drive(0, 0, 0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", in_pixel_ready, 1);
        check_eq("post_rst_state", dbg_state, 0);

        // Fill from reset: 32 writes with the window stalled.
        for (int k = 0; k < 32; k++) begin
            drive(1, k[7:0], 0);
            check_eq("fill_wr", lb_wr_valid, 4'b0001 << (k / 8));
            check_eq("fill_wvalid", window_valid, (k >= 25) ? 1 : 0);
            if (k == 25) check_eq("first_window", out_window, WIN_SEL0);
        end

        // Full stall: a valid pixel must not be written.
        drive(1, 8'hEE, 0);
        check_eq("full_ready", in_pixel_ready, 0);
        check_eq("full_wr", lb_wr_valid, 0);
        @(posedge clk); #1;
        check_eq("full_fill", dut.fill_cnt, 32);
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1);
            check_eq("drain_rd", lb_rd_ready, 4'b0111);
        end
        drive(0, 0, 0);
        check_eq("drain_fill", dut.fill_cnt, 24);
        check_eq("drain_ready", in_pixel_ready, 1);
        check_eq("drain_wrsel", dut.wr_buf_sel, 0);
        check_eq("drain_rdsel", dut.rd_buf_sel, 1);
        check_eq("drain_irq", line_done_irq, 1);
        check_eq("drain_wvalid", window_valid, 1);
        check_eq("drain_window", out_window, WIN_SEL1);
        drive(0, 0, 0);
        check_eq("irq_one_cycle", line_done_irq, 0);

        // Simultaneous write and last read with fill at 31.
        for (int k = 0; k < 7; k++) begin
            drive(1, 8'h40 + k[7:0], 0);
            check_eq("sim_wr", lb_wr_valid, 4'b0001);
        end
        for (int k = 0; k < 7; k++) drive(0, 0, 1);
        drive(1, 8'h47, 1);
        check_eq("sim_pre_fill", dut.fill_cnt, 31);
        check_eq("sim_wr_last", lb_wr_valid, 4'b0001);
        check_eq("sim_rd_last", lb_rd_ready, 4'b1110);
        drive(0, 0, 0);
        check_eq("sim_fill", dut.fill_cnt, 24);
        check_eq("sim_state", dbg_state, 1);
        check_eq("sim_irq", line_done_irq, 1);
        check_eq("sim_rdsel", dut.rd_buf_sel, 2);
        check_eq("sim_wrsel", dut.wr_buf_sel, 1);
        check_eq("sim_wrpix", dut.wr_pix_cnt, 0);

        // Downstream back-pressure 1,0,0,1.
        drive(0, 0, 1);
        check_eq("bp_rd1", lb_rd_ready, 4'b1101);
        drive(0, 0, 0);
        check_eq("bp_rd0a", lb_rd_ready, 0);
        check_eq("bp_win0a", out_window, WIN_SEL2);
        drive(0, 0, 0);
        check_eq("bp_rd0b", lb_rd_ready, 0);
        check_eq("bp_win0b", out_window, WIN_SEL2);
        check_eq("bp_wvalid", window_valid, 1);
        drive(0, 0, 1);
        check_eq("bp_rd1b", lb_rd_ready, 4'b1101);
        drive(0, 0, 0);
        check_eq("bp_rdpix", dut.rd_pix_cnt, 2);

        // Mid-line reset during READ.
        @(negedge clk);
        window_ready = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("mrst_wvalid", window_valid, 0);
        check_eq("mrst_rd", lb_rd_ready, 0);
        check_eq("mrst_window", out_window, 0);
        check_eq("mrst_state", dbg_state, 0);
        check_eq("mrst_irq", line_done_irq, 0);
        @(negedge clk);
        rst = 1'b0;
        window_ready = 1'b0;
        #1;
        check_eq("mrst_fill", dut.fill_cnt, 0);
        check_eq("mrst_rdsel", dut.rd_buf_sel, 0);
        check_eq("mrst_rdpix", dut.rd_pix_cnt, 0);
        check_eq("mrst_wrsel", dut.wr_buf_sel, 0);
        check_eq("mrst_wrpix", dut.wr_pix_cnt, 0);

        // Continuous streaming: 80 accepted pixels, window always consumed.
        sent = 0; pulses = 0; gaps = 0; cyc = 0; seen_valid = 0;
        while (sent < 80 && cyc < 300) begin
            drive(1, sent[7:0], 1);
            if (line_done_irq) begin
                if (pulses < 6) check_eq("stream_rdsel", dut.rd_buf_sel, sel_tab[pulses]);
                pulses++;
            end
            if (window_valid) begin
                if (!seen_valid) check_eq("stream_first_sel", dut.rd_buf_sel, 0);
                seen_valid = 1;
            end else if (seen_valid) begin
                gaps++;
            end
            if (in_pixel_ready) begin
                check_eq("stream_wr", lb_wr_valid, 4'b0001 << ((sent / 8) % 4));
                sent++;
            end
            cyc++;
        end
        check_eq("stream_sent", sent, 80);
        check_eq("stream_pulses", pulses, 6);
        check_eq("stream_gaps", gaps, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
